alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 39 +++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcodes, FSM state type and default multiply latency for the ALU arbiter.
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd1;

    localparam int DEFAULT_MUL_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches from ptr+1 and returns a one-hot grant plus its index.
// Build option ALU_ARB_FIXED_PRIO_EN: ignore ptr and always favour the lowest index.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Starting the scan just past NUM_REQ-1 turns the rotating search into plain lowest-index priority.
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign start = IDX_W'(NUM_REQ - 1);
`else
    assign start = ptr;
`endif

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(start) + k) % NUM_REQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters, one command in flight at a time.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [4*NUM_REQ-1:0]       req_op,
    input  logic [DATA_W*NUM_REQ-1:0]  req_a,
    input  logic [DATA_W*NUM_REQ-1:0]  req_b,
    output logic [3:0]                 alu_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic [DATA_W-1:0]          alu_result,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   id_q;
    logic [3:0]         op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic [3:0]         win_op;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx)
    );

    assign win_op = req_op[4*win_idx +: 4];

    // Grants are also masked while reset is held so every output reads 0 during reset.
    assign req_ready = (state == ST_IDLE && rst) ? win_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            ptr    <= IDX_W'(NUM_REQ - 1);
            cnt    <= '0;
            id_q   <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_ready) begin
                        op_q  <= win_op;
                        a_q   <= req_a[DATA_W*win_idx +: DATA_W];
                        b_q   <= req_b[DATA_W*win_idx +: DATA_W];
                        id_q  <= win_idx;
                        cnt   <= (win_op == OP_MUL) ? MUL_CNT : '0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        data_q <= alu_result;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                        ptr <= ptr;
`else
                        ptr <= id_q;
`endif
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu_op    = (state == ST_EXEC) ? op_q : '0;
    assign alu_a     = (state == ST_EXEC) ? a_q  : '0;
    assign alu_b     = (state == ST_EXEC) ? b_q  : '0;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level arbitration model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [4*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic [3:0]                alu_op;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [DATA_W-1:0]         alu_result;
    logic                      rsp_valid;
    logic [IDX_W-1:0]          rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_ready;
    logic                      busy;

    logic              pendValid [NUM_REQ];
    logic [3:0]        pendOp    [NUM_REQ];
    logic [DATA_W-1:0] pendA     [NUM_REQ];
    logic [DATA_W-1:0] pendB     [NUM_REQ];
    int                mdlPtr;
    int                testsRun    = 0;
    int                testsFailed = 0;
    logic [DATA_W-1:0] obsData;
    int                obsExec;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the team ALU: add, multiply, everything else returns 0.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_MUL:  alu_result = alu_a * alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] modelResult(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        if (op == OP_ADD) return a + b;
        if (op == OP_MUL) return prod[DATA_W-1:0];
        return '0;
    endfunction

    function automatic int modelPick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++)
            if (pendValid[i]) return i;
`else
        for (int k = 1; k <= NUM_REQ; k++)
            if (pendValid[(mdlPtr + k) % NUM_REQ]) return (mdlPtr + k) % NUM_REQ;
`endif
        return -1;
    endfunction

    task automatic drivePending();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]               = pendValid[i];
            req_op[4*i +: 4]           = pendOp[i];
            req_a[DATA_W*i +: DATA_W]  = pendA[i];
            req_b[DATA_W*i +: DATA_W]  = pendB[i];
        end
    endtask

    task automatic setCommand(input int i, input logic [3:0] op, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] b);
        pendValid[i] = 1'b1;
        pendOp[i]    = op;
        pendA[i]     = a;
        pendB[i]     = b;
    endtask

    task automatic newCommand(input int i);
        int sel;
        sel = int'($urandom_range(0, 4));
        if (sel < 2)       setCommand(i, OP_ADD, $urandom, $urandom);
        else if (sel < 4)  setCommand(i, OP_MUL, $urandom, $urandom);
        else               setCommand(i, 4'($urandom_range(2, 15)), $urandom, $urandom);
    endtask

    task automatic refill(input bit all);
        bit any;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (!pendValid[i] && (all || $urandom_range(0, 1) == 1)) newCommand(i);
        for (int i = 0; i < NUM_REQ; i++)
            any |= pendValid[i];
        if (!any) newCommand(int'($urandom_range(0, NUM_REQ - 1)));
    endtask

    task automatic doReset();
        rst       = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) setCommand(i, OP_ADD, '0, '0);
        for (int i = 0; i < NUM_REQ; i++) pendValid[i] = 1'b0;
        drivePending();
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mdlPtr = NUM_REQ - 1;
    endtask

    // One full transaction, entered mid-cycle while the DUT is idle with requests already driven.
    task automatic applyStimulus(input int stall, input int addIdx,
                                 output logic [DATA_W-1:0] gotData, output int gotExec);
        int                 w;
        int                 waitCnt;
        int                 expExec;
        logic [3:0]         op;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [DATA_W-1:0]  expData;
        logic [NUM_REQ-1:0] expGrant;
        logic               aluOk;

        gotData = '0;
        gotExec = 0;
        w = modelPick();
        if (w < 0) return;
        op       = pendOp[w];
        a        = pendA[w];
        b        = pendB[w];
        expData  = modelResult(op, a, b);
        expExec  = (op == OP_MUL) ? MUL_LAT : 1;
        expGrant = '0;
        expGrant[w] = 1'b1;
        rsp_ready = (stall == 0);

        waitCnt = 0;
        while (req_ready == '0 && waitCnt < 8) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("grant_delay", 64'(waitCnt), 64'd0);
        checkOutput("grant", 64'(req_ready), 64'(expGrant));
        if (req_ready == '0) return;

        @(posedge clk);
        #1;
        pendValid[w] = 1'b0;
        if (addIdx >= 0) newCommand(addIdx);
        drivePending();

        aluOk = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) break;
            gotExec++;
            if (alu_op !== op || alu_a !== a || alu_b !== b || busy !== 1'b1 || req_ready !== '0)
                aluOk = 1'b0;
        end
        checkOutput("exec_cycles", 64'(gotExec), 64'(expExec));
        checkOutput("exec_drive", 64'(aluOk), 64'd1);
        if (!rsp_valid) return;

        gotData = rsp_data;
        checkOutput("rsp_id", 64'(rsp_id), 64'(w));
        checkOutput("rsp_data", 64'(rsp_data), 64'(expData));
        checkOutput("resp_idle_alu", {alu_op, alu_a, alu_b != '0, req_ready, busy},
                    {4'd0, 32'd0, 1'b0, 4'd0, 1'b1});

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            checkOutput("stall_hold", {rsp_valid, rsp_id, rsp_data, req_ready},
                        {1'b1, IDX_W'(w), expData, 4'd0});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        mdlPtr = w;
`endif
        checkOutput("back_to_idle", {busy, rsp_valid}, 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) setCommand(i, OP_ADD, '0, '0);
        for (int i = 0; i < NUM_REQ; i++) pendValid[i] = 1'b0;
        setCommand(0, OP_ADD, 32'd5, 32'd7);
        drivePending();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ctrl", {req_ready, alu_op, rsp_valid, rsp_id, busy}, 64'd0);
        checkOutput("reset_data", {alu_a != '0, alu_b != '0, rsp_data != '0}, 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        mdlPtr = NUM_REQ - 1;
        #1;

        // Simple add from requester 0 straight out of reset.
        applyStimulus(0, -1, obsData, obsExec);
        checkOutput("add_5_7", 64'(obsData), 64'd12);
        checkOutput("add_latency", 64'(obsExec + 1), 64'd2);

        @(negedge clk);
        setCommand(1, OP_MUL, 32'd6, 32'd9);
        drivePending();
        #1;
        applyStimulus(0, -1, obsData, obsExec);
        checkOutput("mul_6_9", 64'(obsData), 64'd54);
        checkOutput("mul_exec", 64'(obsExec), 64'(MUL_LAT));

        // Long response stall while requester 2 arrives; it must win right after release.
        @(negedge clk);
        setCommand(3, OP_ADD, 32'd100, 32'd23);
        drivePending();
        #1;
        applyStimulus(10, 2, obsData, obsExec);
        @(negedge clk);
        drivePending();
        #1;
        checkOutput("post_stall_grant", 64'(req_ready), 64'b0100);
        applyStimulus(0, -1, obsData, obsExec);

        // Reset in the middle of a multiply abandons it.
        @(negedge clk);
        setCommand(1, OP_MUL, 32'd3, 32'd4);
        drivePending();
        #1;
        checkOutput("abort_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        #1;
        checkOutput("abort_exec_op", 64'(alu_op), 64'(OP_MUL));
        rst = 1'b0;
        pendValid[1] = 1'b0;
        drivePending();
        #1;
        checkOutput("abort_ctrl", {req_ready, alu_op, rsp_valid, rsp_id, busy}, 64'd0);
        checkOutput("abort_data", {alu_a != '0, alu_b != '0, rsp_data != '0}, 64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mdlPtr = NUM_REQ - 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checkOutput("no_orphan_rsp", {rsp_valid, busy}, 64'd0);
        end
        setCommand(1, OP_ADD, 32'd1, 32'd1);
        setCommand(0, OP_ADD, 32'd2, 32'd2);
        drivePending();
        #1;
        checkOutput("first_after_abort", 64'(req_ready), 64'b0001);
        applyStimulus(0, -1, obsData, obsExec);

        // All requesters continuously valid from a fresh reset.
        doReset();
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            refill(1'b1);
            drivePending();
            #1;
            applyStimulus(0, -1, obsData, obsExec);
        end

        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            refill(1'b0);
            drivePending();
            #1;
            applyStimulus(($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3)), -1, obsData, obsExec);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
